// File: rtl/imm_ext_pkg.sv
// Shared encodings and default widths for the immediate extender pipeline.
// Used by imm_ext_core and imm_extend_pipe.
package imm_ext_pkg;

  localparam int DEF_IN_W  = 26;
  localparam int DEF_OUT_W = 32;
  localparam int DEF_W0    = 16;
  localparam int DEF_W1    = 21;
  localparam int DEF_W2    = 26;

  typedef enum logic [1:0] {
    FMT_W0   = 2'd0,
    FMT_W1   = 2'd1,
    FMT_W2   = 2'd2,
    FMT_FULL = 2'd3
  } imm_fmt_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: selects a field width by format and
// sign/zero fills the upper bits. Optional shift-by-2 under IMMEXT_SHL2_EN.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int W0    = DEF_W0,
  parameter int W1    = DEF_W1,
  parameter int W2    = DEF_W2
) (
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       fmt,
  input  logic             sign,
`ifdef IMMEXT_SHL2_EN
  input  logic             shl2,
`endif
  output logic [OUT_W-1:0] result
);

  logic             fill;
  logic [OUT_W-1:0] ext_full;

  always_comb begin
    fill = 1'b0;
    case (imm_fmt_e'(fmt))
      FMT_W0:   fill = sign & in_imm[W0-1];
      FMT_W1:   fill = sign & in_imm[W1-1];
      FMT_W2:   fill = sign & in_imm[W2-1];
      FMT_FULL: fill = sign & in_imm[IN_W-1];
      default:  fill = 1'b0;
    endcase
  end

  // Each bit knows at elaboration which formats include it in the field.
  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_bit
    if (gi < IN_W) begin : g_field
      localparam logic [3:0] IN_FIELD = {1'b1, (gi < W2), (gi < W1), (gi < W0)};
      assign ext_full[gi] = IN_FIELD[fmt] ? in_imm[gi] : fill;
    end else begin : g_fill
      assign ext_full[gi] = fill;
    end
  end

`ifdef IMMEXT_SHL2_EN
  // OUT_W >= IN_W + 2, so the two bits shifted out are always fill copies.
  assign result = shl2 ? {ext_full[OUT_W-3:0], 2'b00} : ext_full;
`else
  assign result = ext_full;
`endif

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extender behind a 2-entry skid buffer with valid/ready on both
// sides. Optional in_shl2 port under IMMEXT_SHL2_EN.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int W0    = DEF_W0,
  parameter int W1    = DEF_W1,
  parameter int W2    = DEF_W2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_fmt,
  input  logic             in_sign,
`ifdef IMMEXT_SHL2_EN
  input  logic             in_shl2,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm
);

  logic [OUT_W-1:0] ext_value;
  logic [OUT_W-1:0] main_reg, main_next;
  logic [OUT_W-1:0] skid_reg, skid_next;
  skid_state_e      state_reg, state_next;
  logic             in_ready_reg, in_ready_next;
  logic             in_xfer, out_xfer;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .W0    (W0),
    .W1    (W1),
    .W2    (W2)
  ) u_core (
    .in_imm (in_imm),
    .fmt    (in_fmt),
    .sign   (in_sign),
`ifdef IMMEXT_SHL2_EN
    .shl2   (in_shl2),
`endif
    .result (ext_value)
  );

  assign in_ready  = in_ready_reg;
  assign out_valid = (state_reg != EMPTY);
  assign out_imm   = main_reg;
  assign in_xfer   = in_valid & in_ready_reg;
  assign out_xfer  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= EMPTY;
      main_reg     <= '0;
      skid_reg     <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      main_reg     <= main_next;
      skid_reg     <= skid_next;
      in_ready_reg <= in_ready_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    case (state_reg)
      EMPTY: begin
        if (in_xfer) begin
          main_next  = ext_value;
          state_next = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_next = ext_value;
        end else if (in_xfer) begin
          skid_next  = ext_value;
          state_next = FULL;
        end else if (out_xfer) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the output side can move.
        if (out_xfer) begin
          main_next  = skid_reg;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
    in_ready_next = (state_next != FULL);
  end

endmodule
